mem_sync_arbiter: RTL and testbench

- Next-generation memory/row-cache synchroniser for the PiMulator bank model.
- Per bank, keeps a direct-mapped table of which DRAM row occupies each cache row.
- On a synchronised activate it detects hits and misses. On a miss it writes back the dirty victim row, then fetches the new row.
- All banks across all ranks share one backing-store transfer port through a round-robin arbiter. A global stall holds the timing FSMs until every bank is idle.

---
 rtl/mem_sync_pkg.sv | 24 ++
 rtl/mem_sync_bank.sv | 103 ++++++++++
 rtl/mem_sync_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_sync_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sync_pkg.sv
// Shared definitions for the PiMulator row-cache synchroniser: BankFSM command
// codes, per-bank synchroniser states and the flat bank-id helper.
package mem_sync_pkg;

    localparam logic [4:0] FSM_ACT = 5'b00001;
    localparam logic [4:0] FSM_PR  = 5'b01010;
    localparam logic [4:0] FSM_RD0 = 5'b01011;
    localparam logic [4:0] FSM_RD1 = 5'b01100;
    localparam logic [4:0] FSM_WR0 = 5'b10010;
    localparam logic [4:0] FSM_WR1 = 5'b10011;

    typedef logic [1:0] bank_state_t;

    localparam bank_state_t IDLE  = 2'd0;
    localparam bank_state_t EVICT = 2'd1;
    localparam bank_state_t FETCH = 2'd2;

    // Flat bank id laid out as {rank, bank group, bank}.
    function automatic int flat_bank_id(input int rk, input int bg, input int ba,
                                        input int bgw, input int baw);
        return (rk << (bgw + baw)) | (bg << baw) | ba;
    endfunction

endpackage

// File: rtl/mem_sync_bank.sv
// One bank's direct-mapped row table, miss FSM (IDLE/EVICT/FETCH) and cRowId register.
// With SYNC_STATS_EN defined, also exports per-cycle hit/miss pulses.
module mem_sync_bank
    import mem_sync_pkg::*;
#(
    parameter int CHWIDTH   = 5,
    parameter int ADDRWIDTH = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDRWIDTH-1:0] row_id,
    input  logic [4:0]           bank_fsm,
    input  logic                 sync,
    input  logic                 xfer_ack,
    output logic [CHWIDTH-1:0]   c_row_id,
    output logic                 req,
    output logic                 req_wr,
    output logic [ADDRWIDTH-1:0] req_row,
    output logic [CHWIDTH-1:0]   req_crow
`ifdef SYNC_STATS_EN
    ,
    output logic                 hit,
    output logic                 miss
`endif
);

    localparam int CHROWS = 2 ** CHWIDTH;
    localparam int TAGW   = ADDRWIDTH - CHWIDTH;

    logic [TAGW-1:0]      tag_tbl [CHROWS];
    logic [CHROWS-1:0]    valid;
    logic [CHROWS-1:0]    dirty;
    bank_state_t          state;
    logic                 act_q;
    logic [ADDRWIDTH-1:0] lat_row;

    logic                 is_act;
    logic                 is_wr;
    logic                 lookup;
    logic                 hit_now;
    logic [CHWIDTH-1:0]   idx;
    logic [TAGW-1:0]      tag;
    logic [CHWIDTH-1:0]   lat_idx;

    assign is_act  = (bank_fsm == FSM_ACT);
    assign is_wr   = (bank_fsm == FSM_WR0) || (bank_fsm == FSM_WR1);
    assign idx     = row_id[CHWIDTH-1:0];
    assign tag     = row_id[ADDRWIDTH-1:CHWIDTH];
    assign lat_idx = lat_row[CHWIDTH-1:0];
    assign lookup  = is_act && !act_q && sync && (state == IDLE);
    assign hit_now = valid[idx] && (tag_tbl[idx] == tag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHROWS; i++) tag_tbl[i] <= '0;
            valid    <= '0;
            dirty    <= '0;
            state    <= IDLE;
            act_q    <= 1'b0;
            lat_row  <= '0;
            c_row_id <= '0;
        end else begin
            act_q <= is_act;
            case (state)
                IDLE: begin
                    if (lookup) begin
                        c_row_id <= idx;
                        if (!hit_now) begin
                            lat_row <= row_id;
                            state   <= (valid[idx] && dirty[idx]) ? EVICT : FETCH;
                        end
                    end else if (is_wr) begin
                        dirty[c_row_id] <= 1'b1;
                    end
                end
                EVICT: begin
                    if (xfer_ack) state <= FETCH;
                end
                FETCH: begin
                    if (xfer_ack) begin
                        tag_tbl[lat_idx] <= lat_row[ADDRWIDTH-1:CHWIDTH];
                        valid[lat_idx]   <= 1'b1;
                        dirty[lat_idx]   <= 1'b0;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // While evicting, the table still holds the victim's tag at lat_idx.
    assign req      = (state != IDLE);
    assign req_wr   = (state == EVICT);
    assign req_row  = (state == EVICT) ? {tag_tbl[lat_idx], lat_idx} : lat_row;
    assign req_crow = lat_idx;

`ifdef SYNC_STATS_EN
    assign hit  = lookup && hit_now;
    assign miss = lookup && !hit_now;
`endif

endmodule

// File: rtl/mem_sync_arbiter.sv
// Top: one mem_sync_bank per bank plus a round-robin arbiter for the shared transfer port.
// Optional SYNC_STATS_EN adds saturating hit/miss/evict counters.
module mem_sync_arbiter
    import mem_sync_pkg::*;
#(
    parameter int RKWIDTH   = 1,
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int CHWIDTH   = 5,
    parameter int ADDRWIDTH = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic [2**RKWIDTH-1:0][2**BGWIDTH-1:0][2**BAWIDTH-1:0][ADDRWIDTH-1:0] RowId,
    input  logic [2**RKWIDTH-1:0][2**BGWIDTH-1:0][2**BAWIDTH-1:0][4:0]           BankFSM,
    input  logic [2**RKWIDTH-1:0][2**BGWIDTH-1:0][2**BAWIDTH-1:0]                sync,
    output logic [2**RKWIDTH-1:0][2**BGWIDTH-1:0][2**BAWIDTH-1:0][CHWIDTH-1:0]   cRowId,
    output logic stall,
    output logic xfer_req,
    output logic xfer_wr,
    output logic [RKWIDTH+BGWIDTH+BAWIDTH-1:0] xfer_bank,
    output logic [ADDRWIDTH-1:0] xfer_row,
    output logic [CHWIDTH-1:0]   xfer_crow,
    input  logic xfer_ack
`ifdef SYNC_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt,
    output logic [31:0] evict_cnt
`endif
);

    localparam int RANKS         = 2 ** RKWIDTH;
    localparam int BANKGROUPS    = 2 ** BGWIDTH;
    localparam int BANKSPERGROUP = 2 ** BAWIDTH;
    localparam int NBANKS        = RANKS * BANKGROUPS * BANKSPERGROUP;
    localparam int BIDW          = RKWIDTH + BGWIDTH + BAWIDTH;

    logic [NBANKS-1:0]    bank_req;
    logic [NBANKS-1:0]    bank_wr;
    logic [NBANKS-1:0]    bank_ack;
    logic [ADDRWIDTH-1:0] bank_row    [NBANKS];
    logic [CHWIDTH-1:0]   bank_crow   [NBANKS];
    logic [CHWIDTH-1:0]   bank_c_row  [NBANKS];
`ifdef SYNC_STATS_EN
    logic [NBANKS-1:0]    bank_hit;
    logic [NBANKS-1:0]    bank_miss;
`endif

    logic [BIDW-1:0] ptr;
    logic [BIDW-1:0] grant_id;
    logic [BIDW-1:0] cand;
    logic            grant_valid;

    for (genvar r = 0; r < RANKS; r++) begin : g_rank
        for (genvar g = 0; g < BANKGROUPS; g++) begin : g_group
            for (genvar b = 0; b < BANKSPERGROUP; b++) begin : g_bank
                localparam int ID = flat_bank_id(r, g, b, BGWIDTH, BAWIDTH);
                mem_sync_bank #(
                    .CHWIDTH  (CHWIDTH),
                    .ADDRWIDTH(ADDRWIDTH)
                ) u_bank (
                    .clk     (clk),
                    .rst     (rst),
                    .row_id  (RowId[r][g][b]),
                    .bank_fsm(BankFSM[r][g][b]),
                    .sync    (sync[r][g][b]),
                    .xfer_ack(bank_ack[ID]),
                    .c_row_id(bank_c_row[ID]),
                    .req     (bank_req[ID]),
                    .req_wr  (bank_wr[ID]),
                    .req_row (bank_row[ID]),
                    .req_crow(bank_crow[ID])
`ifdef SYNC_STATS_EN
                    ,
                    .hit     (bank_hit[ID]),
                    .miss    (bank_miss[ID])
`endif
                );
            end
        end
    end

    always_comb begin
        for (int r = 0; r < RANKS; r++)
            for (int g = 0; g < BANKGROUPS; g++)
                for (int b = 0; b < BANKSPERGROUP; b++)
                    cRowId[r][g][b] = bank_c_row[flat_bank_id(r, g, b, BGWIDTH, BAWIDTH)];
    end

    always_comb begin
        for (int i = 0; i < NBANKS; i++)
            bank_ack[i] = xfer_req && xfer_ack && (xfer_bank == BIDW'(i));
    end

    assign stall = |bank_req;

    // Scan downward so the requester closest above the pointer wins; NBANKS is a power of two, so wrap is free.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = NBANKS - 1; k >= 0; k--) begin
            cand = ptr + BIDW'(k);
            if (bank_req[cand]) begin
                grant_valid = 1'b1;
                grant_id    = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_req  <= 1'b0;
            xfer_wr   <= 1'b0;
            xfer_bank <= '0;
            xfer_row  <= '0;
            xfer_crow <= '0;
            ptr       <= '0;
        end else if (xfer_req) begin
            if (xfer_ack) begin
                xfer_req <= 1'b0;
                ptr      <= xfer_bank + BIDW'(1);
            end
        end else if (grant_valid) begin
            xfer_req  <= 1'b1;
            xfer_wr   <= bank_wr[grant_id];
            xfer_bank <= grant_id;
            xfer_row  <= bank_row[grant_id];
            xfer_crow <= bank_crow[grant_id];
        end
    end

`ifdef SYNC_STATS_EN
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? '1 : s[31:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            evict_cnt <= '0;
        end else begin
            hit_cnt  <= sat_add(hit_cnt, 32'($countones(bank_hit)));
            miss_cnt <= sat_add(miss_cnt, 32'($countones(bank_miss)));
            if (xfer_req && xfer_ack && xfer_wr)
                evict_cnt <= sat_add(evict_cnt, 32'd1);
        end
    end
`endif

endmodule

// File: tb/tb_mem_sync_arbiter.sv
// Scoreboard bench for mem_sync_arbiter: expected transfers are queued when a miss is
// provoked and compared when the DUT raises xfer_req.
module tb_mem_sync_arbiter;

    localparam int RANKS = 2;
    localparam int BG    = 4;
    localparam int BA    = 4;
    localparam int AW    = 17;
    localparam int CW    = 5;

    localparam logic [4:0] CMD_NONE = 5'b00000;
    localparam logic [4:0] CMD_ACT  = 5'b00001;
    localparam logic [4:0] CMD_WR   = 5'b10010;

    typedef struct packed {
        logic          wr;
        logic [4:0]    bank;
        logic [AW-1:0] row;
        logic [CW-1:0] crow;
    } xfer_t;

    logic clk;
    logic rst;
    logic [RANKS-1:0][BG-1:0][BA-1:0][AW-1:0] row_id;
    logic [RANKS-1:0][BG-1:0][BA-1:0][4:0]    bank_fsm;
    logic [RANKS-1:0][BG-1:0][BA-1:0]         sync;
    logic [RANKS-1:0][BG-1:0][BA-1:0][CW-1:0] c_row_id;
    logic          stall;
    logic          xfer_req;
    logic          xfer_wr;
    logic [4:0]    xfer_bank;
    logic [AW-1:0] xfer_row;
    logic [CW-1:0] xfer_crow;
    logic          xfer_ack;

    xfer_t exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    mem_sync_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .RowId    (row_id),
        .BankFSM  (bank_fsm),
        .sync     (sync),
        .cRowId   (c_row_id),
        .stall    (stall),
        .xfer_req (xfer_req),
        .xfer_wr  (xfer_wr),
        .xfer_bank(xfer_bank),
        .xfer_row (xfer_row),
        .xfer_crow(xfer_crow),
        .xfer_ack (xfer_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    task automatic applyStimulus(input int id, input logic [AW-1:0] row, input logic [4:0] cmd, input logic s);
        row_id[id / (BG * BA)][(id / BA) % BG][id % BA]   = row;
        bank_fsm[id / (BG * BA)][(id / BA) % BG][id % BA] = cmd;
        sync[id / (BG * BA)][(id / BA) % BG][id % BA]     = s;
    endtask

    task automatic clearCommands();
        bank_fsm = '0;
    endtask

    function automatic logic [CW-1:0] crowOf(input int id);
        return c_row_id[id / (BG * BA)][(id / BA) % BG][id % BA];
    endfunction

    function automatic xfer_t mkXfer(input logic wr, input int bank, input logic [AW-1:0] row);
        xfer_t t;
        t.wr   = wr;
        t.bank = 5'(bank);
        t.row  = row;
        t.crow = row[CW-1:0];
        return t;
    endfunction

    // Issue one cycle of commands, then drop them so the next ACT is a fresh edge.
    task automatic stepAndClear();
        @(negedge clk);
        clearCommands();
    endtask

    task automatic serviceTransfer(input string tag, input int hold);
        xfer_t e;
        int    waited;
        waited = 0;
        while (!xfer_req && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() == 0) begin
            checkOutput({tag, "_unexpected"}, 32'(xfer_req), 32'd0);
            return;
        end
        e = exp_q.pop_front();
        checkOutput({tag, "_req"}, 32'(xfer_req), 32'd1);
        if (!xfer_req) return;
        checkOutput({tag, "_wr"},   32'(xfer_wr),   32'(e.wr));
        checkOutput({tag, "_bank"}, 32'(xfer_bank), 32'(e.bank));
        checkOutput({tag, "_row"},  32'(xfer_row),  32'(e.row));
        checkOutput({tag, "_crow"}, 32'(xfer_crow), 32'(e.crow));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput({tag, "_hold_req"}, 32'(xfer_req), 32'd1);
            checkOutput({tag, "_hold_row"}, 32'(xfer_row), 32'(e.row));
        end
        xfer_ack = 1'b1;
        @(negedge clk);
        xfer_ack = 1'b0;
        checkOutput({tag, "_req_drop"}, 32'(xfer_req), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        xfer_ack = 1'b0;
        row_id   = '0;
        bank_fsm = '0;
        sync     = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        checkOutput("reset_stall", 32'(stall), 32'd0);
        checkOutput("reset_req", 32'(xfer_req), 32'd0);
        checkOutput("reset_crow0", 32'(crowOf(0)), 32'd0);

        // Cold miss on bank 0
        exp_q.push_back(mkXfer(1'b0, 0, 17'h00045));
        applyStimulus(0, 17'h00045, CMD_ACT, 1'b1);
        stepAndClear();
        checkOutput("cold_stall", 32'(stall), 32'd1);
        serviceTransfer("cold", 2);
        checkOutput("cold_stall_done", 32'(stall), 32'd0);
        checkOutput("cold_crow", 32'(crowOf(0)), 32'd5);

        // Hit on the same row
        applyStimulus(0, 17'h00045, CMD_ACT, 1'b1);
        stepAndClear();
        for (int i = 0; i < 3; i++) begin
            checkOutput("hit_stall", 32'(stall), 32'd0);
            checkOutput("hit_req", 32'(xfer_req), 32'd0);
            @(negedge clk);
        end
        checkOutput("hit_crow", 32'(crowOf(0)), 32'd5);

        // Dirty victim: writeback of 0x45, then fetch of 0x65 into cache row 5
        applyStimulus(0, 17'h00045, CMD_WR, 1'b1);
        stepAndClear();
        exp_q.push_back(mkXfer(1'b1, 0, 17'h00045));
        exp_q.push_back(mkXfer(1'b0, 0, 17'h00065));
        applyStimulus(0, 17'h00065, CMD_ACT, 1'b1);
        stepAndClear();
        serviceTransfer("evict", 0);
        checkOutput("evict_stall_between", 32'(stall), 32'd1);
        serviceTransfer("evict_fetch", 1);
        checkOutput("evict_stall_done", 32'(stall), 32'd0);
        checkOutput("evict_crow", 32'(crowOf(0)), 32'd5);

        // Round-robin from pointer 0: banks 3 and 9, then 5 and 12 with the pointer at 10
        @(negedge clk);
        rst = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
        exp_q.push_back(mkXfer(1'b0, 3, 17'h00100));
        exp_q.push_back(mkXfer(1'b0, 9, 17'h001E3));
        applyStimulus(9, 17'h001E3, CMD_ACT, 1'b1);
        applyStimulus(3, 17'h00100, CMD_ACT, 1'b1);
        stepAndClear();
        serviceTransfer("rr_first", 0);
        serviceTransfer("rr_second", 0);
        exp_q.push_back(mkXfer(1'b0, 12, 17'h000AA));
        exp_q.push_back(mkXfer(1'b0, 5, 17'h000B1));
        applyStimulus(5, 17'h000B1, CMD_ACT, 1'b1);
        applyStimulus(12, 17'h000AA, CMD_ACT, 1'b1);
        stepAndClear();
        serviceTransfer("rr_ptr10_first", 0);
        serviceTransfer("rr_ptr10_second", 0);
        checkOutput("rr_crow12", 32'(crowOf(12)), 32'd10);

        // ACT with sync low performs no lookup
        applyStimulus(12, 17'h001F7, CMD_ACT, 1'b0);
        stepAndClear();
        for (int i = 0; i < 3; i++) begin
            checkOutput("nosync_req", 32'(xfer_req), 32'd0);
            checkOutput("nosync_stall", 32'(stall), 32'd0);
            @(negedge clk);
        end
        checkOutput("nosync_crow", 32'(crowOf(12)), 32'd10);

        // Reset while a fetch is outstanding
        applyStimulus(3, 17'h00222, CMD_ACT, 1'b1);
        stepAndClear();
        for (int i = 0; i < 20 && !xfer_req; i++) @(negedge clk);
        checkOutput("rstmid_req_seen", 32'(xfer_req), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rstmid_req", 32'(xfer_req), 32'd0);
        checkOutput("rstmid_stall", 32'(stall), 32'd0);
        checkOutput("rstmid_crow12", 32'(crowOf(12)), 32'd0);
        #2 rst = 1'b0;
        @(negedge clk);
        exp_q.push_back(mkXfer(1'b0, 3, 17'h00100));
        applyStimulus(3, 17'h00100, CMD_ACT, 1'b1);
        stepAndClear();
        checkOutput("rstmid_remiss_stall", 32'(stall), 32'd1);
        serviceTransfer("rstmid_remiss", 0);

        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
